// File: rtl/imem_loader.sv
// Byte-stream boot loader: receives a length-prefixed, XOR-checksummed program image
// and writes it word by word into instruction memory while holding the core in reset.
module imem_loader #(
   parameter logic [9:0] BASE_ADDR = 10'h080
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic [9:0]  mem_address,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   output logic        core_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [10:0] words_loaded
);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_t;

   state_t      state_reg, state_next;
   logic [7:0]  len_lo_reg;
   logic [10:0] len_reg;
   logic [1:0]  byte_cnt_reg;
   logic [23:0] word_reg;
   logic [7:0]  csum_reg;
   logic [10:0] words_reg;
   logic [9:0]  mem_address_reg;
   logic [31:0] mem_data_reg;
   logic        mem_wren_reg;

   logic        in_load;
   logic        accept;
   logic        can_start;
   logic [15:0] len_full;
   logic        len_bad;
   logic        last_word;

   assign in_load   = (state_reg == LEN_LO) || (state_reg == LEN_HI) ||
                      (state_reg == DATA)   || (state_reg == CHECK);
   assign accept    = byte_valid & in_load;
   assign can_start = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
   assign len_full  = {byte_data, len_lo_reg};
   assign len_bad   = (len_full == 16'd0) || (len_full > 16'd1024);
   assign last_word = (words_reg + 11'd1) == len_reg;

   assign mem_address  = mem_address_reg;
   assign mem_data     = mem_data_reg;
   assign mem_wren     = mem_wren_reg;
   assign words_loaded = words_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      byte_ready = 1'b0;
      busy       = 1'b0;
      core_rst_n = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state_reg)
         IDLE: begin
            core_rst_n = 1'b1;
            if (start) state_next = LEN_LO;
         end
         LEN_LO: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) state_next = LEN_HI;
         end
         LEN_HI: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) state_next = len_bad ? ERR : DATA;
         end
         DATA: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid && (byte_cnt_reg == 2'd3) && last_word) state_next = CHECK;
         end
         CHECK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) state_next = (byte_data == csum_reg) ? DONE : ERR;
         end
         DONE: begin
            core_rst_n = 1'b1;
            done       = 1'b1;
            if (start) state_next = LEN_LO;
         end
         ERR: begin
            error = 1'b1;
            if (start) state_next = LEN_LO;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bytes shift in from the top so byte 0 ends up in bits 7:0 once the word is complete.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_lo_reg      <= 8'd0;
         len_reg         <= 11'd0;
         byte_cnt_reg    <= 2'd0;
         word_reg        <= 24'd0;
         csum_reg        <= 8'd0;
         words_reg       <= 11'd0;
         mem_address_reg <= 10'd0;
         mem_data_reg    <= 32'd0;
         mem_wren_reg    <= 1'b0;
      end else begin
         mem_wren_reg <= 1'b0;
         if (can_start) begin
            words_reg    <= 11'd0;
            csum_reg     <= 8'd0;
            byte_cnt_reg <= 2'd0;
         end
         if (accept) begin
            case (state_reg)
               LEN_LO: len_lo_reg <= byte_data;
               LEN_HI: len_reg    <= len_full[10:0];
               DATA: begin
                  csum_reg     <= csum_reg ^ byte_data;
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == 2'd3) begin
                     mem_data_reg    <= {byte_data, word_reg};
                     mem_address_reg <= BASE_ADDR + words_reg[9:0];
                     mem_wren_reg    <= 1'b1;
                     words_reg       <= words_reg + 11'd1;
                  end else begin
                     word_reg <= {byte_data, word_reg[23:8]};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: two instances (default base and a wrapping base)
// share one byte stream and are compared against a queue-based model of the image format.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'd0;

   logic        br1, wren1, crn1, busy1, done1, err1;
   logic [9:0]  addr1;
   logic [31:0] data1;
   logic [10:0] wl1;
   logic        br2, wren2, crn2, busy2, done2, err2;
   logic [9:0]  addr2;
   logic [31:0] data2;
   logic [10:0] wl2;

   imem_loader dut1 (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(br1), .mem_address(addr1), .mem_data(data1), .mem_wren(wren1),
      .core_rst_n(crn1), .busy(busy1), .done(done1), .error(err1), .words_loaded(wl1)
   );

   imem_loader #(.BASE_ADDR(10'h3FF)) dut2 (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(br2), .mem_address(addr2), .mem_data(data2), .mem_wren(wren2),
      .core_rst_n(crn2), .busy(busy2), .done(done2), .error(err2), .words_loaded(wl2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int stalls = 0;

   logic [9:0]  oa1[$], oa2[$];
   logic [31:0] od1[$], od2[$];
   logic [7:0]  preset[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wren1) begin oa1.push_back(addr1); od1.push_back(data1); end
      if (wren2) begin oa2.push_back(addr2); od2.push_back(data2); end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int   k;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      k = 0;
      r = br1;
      while (!r && k < 20) begin
         stalls++;
         @(negedge clk);
         r = br1;
         k++;
      end
      if (!r) check("byte_accept_timeout", 64'd0, 64'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Model: image = length, 4N little-endian data bytes, XOR checksum of the data bytes.
   task automatic run_load(input logic [15:0] n, input int gapmax, input bit bad_sum, input string name);
      logic [7:0]  d[$];
      logic [7:0]  x, b, cs;
      logic [31:0] w;
      bit          ok_len, ok;
      int          nw;
      ok_len = (n != 16'd0) && (n <= 16'd1024);
      oa1.delete(); oa2.delete(); od1.delete(); od2.delete();
      stalls = 0;
      pulse_start();
      check({name, "_busy_start"}, busy1, 1);
      check({name, "_cleared"}, {done1, err1, crn1, wl1}, 0);
      send_byte(n[7:0], $urandom_range(0, gapmax));
      send_byte(n[15:8], $urandom_range(0, gapmax));
      if (!ok_len) begin
         check({name, "_err_after_len"}, {err1, err2, br1, busy1}, 4'b1100);
      end else begin
         x = 8'd0;
         for (int i = 0; i < 4 * int'(n); i++) begin
            b = (preset.size() > 0) ? preset.pop_front() : 8'($urandom);
            d.push_back(b);
            x = x ^ b;
            send_byte(b, $urandom_range(0, gapmax));
         end
         cs = bad_sum ? x + 8'd1 : x;
         send_byte(cs, $urandom_range(0, gapmax));
      end
      repeat (3) @(negedge clk);
      ok = ok_len && !bad_sum;
      nw = ok_len ? int'(n) : 0;
      check({name, "_done"}, {done1, done2}, {ok, ok});
      check({name, "_error"}, {err1, err2}, {!ok, !ok});
      check({name, "_core_rst_n"}, {crn1, crn2}, {ok, ok});
      check({name, "_idle_outs"}, {busy1, busy2, br1, br2}, 0);
      check({name, "_words_loaded"}, {wl1, wl2}, {11'(nw), 11'(nw)});
      check({name, "_write_count1"}, oa1.size(), nw);
      check({name, "_write_count2"}, oa2.size(), nw);
      for (int i = 0; i < nw && i < oa1.size() && i < oa2.size(); i++) begin
         w = {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
         check({name, "_addr1"}, oa1[i], (128 + i) % 1024);
         check({name, "_data1"}, od1[i], w);
         check({name, "_addr2"}, oa2[i], (1023 + i) % 1024);
         check({name, "_data2"}, od2[i], w);
      end
      $display("load %s: N=%0d bad_sum=%0d writes=%0d done=%0b error=%0b stalls=%0d",
               name, n, bad_sum, oa1.size(), done1, err1, stalls);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ctrl", {br1, busy1, done1, err1, wren1, crn1}, 6'b000001);
      check("rst_data", {addr1, data1, wl1, addr2, wl2}, 0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_outs", {br1, busy1, crn1}, 3'b001);

      preset = '{8'h13, 8'h05, 8'hA0, 8'h00};
      run_load(16'd1, 0, 1'b0, "directed_one");
      check("directed_data", (od1.size() > 0) ? od1[0] : 32'hX, 32'h00A00513);
      check("directed_addr", (oa1.size() > 0) ? oa1[0] : 10'hX, 10'h080);

      run_load(16'd2, 0, 1'b0, "back_to_back");
      check("back_to_back_no_stall", stalls, 0);
      run_load(16'd1, 2, 1'b1, "bad_checksum");
      run_load(16'd0, 1, 1'b0, "len_zero");
      run_load(16'd1025, 1, 1'b0, "len_1025");

      for (int t = 0; t < 8; t++)
         run_load(16'($urandom_range(1, 6)), 3, ($urandom_range(0, 3) == 0), "random");
      run_load(16'd1024, 0, 1'b0, "len_1024");

      // Abort between bytes 2 and 3 of word 0.
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      oa1.delete(); oa2.delete();
      rst = 1'b0;
      #1;
      check("midrst_ctrl", {br1, busy1, done1, err1, wren1, crn1}, 6'b000001);
      check("midrst_data", {addr1, data1, wl1}, 0);
      pulse_start();
      @(negedge clk);
      check("midrst_start_ignored", {busy1, busy2}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_after_release", {busy1, crn1}, 2'b01);
      check("midrst_no_write", oa1.size() + oa2.size(), 0);
      run_load(16'd3, 2, 1'b0, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
